// File: rtl/sr_jk_cmd_sequencer.sv
// JK flip-flop drive stage: buffers set/reset requests in a FIFO and replays them
// as timed j/k pulses separated by a one-cycle gap. It also tracks the expected q.
module sr_jk_cmd_sequencer #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_in,
  input  logic                   r_in,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  output logic                   j,
  output logic                   k,
  output logic                   busy,
  output logic                   q_model,
  output logic                   illegal,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  // Entries are stored as {s,r}: 10 = SET, 01 = RESET, 00 = HOLD.
  logic [1:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [1:0]    state;
  logic [HW-1:0] hold_cnt;
  logic          accept;
  logic          push;
  logic          pop;

  assign cmd_ready = (count < FULL);
  assign accept    = cmd_valid & cmd_ready;
  assign push      = accept & ~(s_in & r_in);
  assign pop       = ((state == IDLE) || (state == GAP)) && (count != '0);
  assign busy      = (state != IDLE) || (count != '0);

  // NOTE: storage array has no reset; validity is tracked by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_in, r_in};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // sees pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      illegal <= 1'b0;
    end else begin
      illegal <= accept & s_in & r_in;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold_cnt <= '0;
      j        <= 1'b0;
      k        <= 1'b0;
      q_model  <= 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (pop) begin
            {j, k}   <= mem[rd_ptr];
            hold_cnt <= HOLD_LOAD;
            state    <= DRIVE;
          end else begin
            j     <= 1'b0;
            k     <= 1'b0;
            state <= IDLE;
          end
        end
        DRIVE: begin
          if (hold_cnt == '0) begin
            // The flip-flop captures the held j/k on this edge, so q follows here.
            if (j)      q_model <= 1'b1;
            else if (k) q_model <= 1'b0;
            j     <= 1'b0;
            k     <= 1'b0;
            state <= GAP;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: begin
          j     <= 1'b0;
          k     <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_jk_cmd_sequencer.sv
// Bench for sr_jk_cmd_sequencer: two instances (HOLD_CYCLES 1 and 3) share stimulus
// and are compared every cycle against a command-timeline reference model.
module tb_sr_jk_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int H0    = 1;
  localparam int H1    = 3;

  logic clk, rst_n, s_in, r_in, cmd_valid;
  logic rdy0, j0, k0, busy0, q0, ill0;
  logic rdy1, j1, k1, busy1, q1, ill1;
  logic [CW-1:0] cnt0, cnt1;

  int n_checks;
  int n_pass;

  // Reference model: pending command list, plus the active command and its
  // position in the slot (0 = no slot, 1..H = driving cycle, H+1 = gap cycle).
  int         hold_of [2];
  logic [1:0] mlist   [2][DEPTH];
  int         msize   [2];
  int         mphase  [2];
  logic [1:0] mact    [2];
  logic       mq      [2];
  logic       mill    [2];

  sr_jk_cmd_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(H0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .s_in(s_in), .r_in(r_in), .cmd_valid(cmd_valid),
    .cmd_ready(rdy0), .j(j0), .k(k0), .busy(busy0), .q_model(q0),
    .illegal(ill0), .count(cnt0)
  );

  sr_jk_cmd_sequencer #(.DEPTH(DEPTH), .HOLD_CYCLES(H1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .s_in(s_in), .r_in(r_in), .cmd_valid(cmd_valid),
    .cmd_ready(rdy1), .j(j1), .k(k1), .busy(busy1), .q_model(q1),
    .illegal(ill1), .count(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      msize[i]  = 0;
      mphase[i] = 0;
      mact[i]   = 2'b00;
      mq[i]     = 1'b0;
      mill[i]   = 1'b0;
    end
  endtask

  // Advances the model by one rising edge using the inputs present at that edge.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit acc;
      bit take;
      acc  = cmd_valid && (msize[i] < DEPTH);
      take = ((mphase[i] == 0) || (mphase[i] == hold_of[i] + 1)) && (msize[i] > 0);
      if (take) begin
        mact[i] = mlist[i][0];
        for (int e = 0; e < DEPTH - 1; e++) mlist[i][e] = mlist[i][e+1];
        msize[i]--;
        mphase[i] = 1;
      end else if (mphase[i] >= 1 && mphase[i] < hold_of[i]) begin
        mphase[i]++;
      end else if (mphase[i] == hold_of[i]) begin
        if (mact[i] == 2'b10) mq[i] = 1'b1;
        if (mact[i] == 2'b01) mq[i] = 1'b0;
        mphase[i] = hold_of[i] + 1;
      end else begin
        mphase[i] = 0;
      end
      mill[i] = acc && s_in && r_in;
      if (acc && !(s_in && r_in)) begin
        mlist[i][msize[i]] = {s_in, r_in};
        msize[i]++;
      end
    end
  endtask

  // Packed as {j, k, busy, q_model, illegal, cmd_ready, count}.
  function automatic logic [8:0] model_vec(int i);
    logic          drv;
    logic [CW-1:0] c;
    drv = (mphase[i] >= 1) && (mphase[i] <= hold_of[i]);
    c   = CW'(msize[i]);
    return {drv && (mact[i] == 2'b10), drv && (mact[i] == 2'b01),
            (mphase[i] != 0) || (msize[i] != 0), mq[i], mill[i],
            msize[i] < DEPTH, c};
  endfunction

  function automatic logic [8:0] dut_vec(int i);
    if (i == 0) return {j0, k0, busy0, q0, ill0, rdy0, cnt0};
    return {j1, k1, busy1, q1, ill1, rdy1, cnt1};
  endfunction

  task automatic compare_all(input string tag);
    check({tag, "_h1"}, 32'(dut_vec(0)), 32'(model_vec(0)));
    check({tag, "_h3"}, 32'(dut_vec(1)), 32'(model_vec(1)));
  endtask

  // Called at a falling edge: drive, take one rising edge, compare at the next fall.
  task automatic step(input bit v, input bit s, input bit r);
    cmd_valid = v;
    s_in      = s;
    r_in      = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all("cyc");
    check("jk_exclusive", {30'd0, j0 & k0, j1 & k1}, 32'd0);
  endtask

  task automatic reset_cycles(input int n);
    cmd_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    model_reset();
    compare_all("rst");
    repeat (n) begin
      @(negedge clk);
      compare_all("rst_hold");
    end
    rst_n = 1'b1;
  endtask

  // Asynchronous reset asserted mid-cycle, released at a later falling edge.
  task automatic async_reset();
    #2;
    cmd_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    model_reset();
    compare_all("arst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    cmd_valid  = 1'b0;
    s_in       = 1'b0;
    r_in       = 1'b0;
    n_checks   = 0;
    n_pass     = 0;
    hold_of[0] = H0;
    hold_of[1] = H1;
    model_reset();
    @(negedge clk);

    reset_cycles(3);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("idle_ready", 32'(rdy0), 32'd1);
    check("idle_busy", 32'(busy0), 32'd0);

    step(1'b1, 1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    check("set_q", 32'(q0), 32'd1);

    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0);
    check("burst_q_h1", 32'(q0), 32'd1);
    check("burst_q_h3", 32'(q1), 32'd1);

    repeat (10) step(1'b1, 1'b0, 1'b1);
    repeat (30) step(1'b0, 1'b0, 1'b0);
    check("full_q_h3", 32'(q1), 32'd0);

    step(1'b1, 1'b1, 1'b1);
    check("illegal_pulse", 32'(ill0), 32'd1);
    step(1'b1, 1'b0, 1'b1);
    check("illegal_clear", 32'(ill0), 32'd0);
    repeat (12) step(1'b0, 1'b0, 1'b0);

    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    check("mid_k_h3", 32'(k1), 32'd1);
    async_reset();
    check("mid_rst_q", 32'(q1), 32'd0);
    check("mid_rst_count", 32'(cnt1), 32'd0);
    check("mid_rst_k", 32'(k1), 32'd0);
    repeat (8) step(1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      else step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
